// File: rtl/if_prefetch_unit_pkg.sv
// rtl/if_prefetch_unit_pkg.sv - shared types and constants for the instruction-fetch front end
package if_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - instruction-memory and decode-side signal bundle of the prefetch unit
interface if_prefetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    modport master (
        output imem_req, imem_addr, ValidD, InstrD, PCD, PCPlus4D,
        input  imem_gnt, imem_rvalid, imem_rdata, StallD, PCSrcE, PCTargetE
    );

    modport slave (
        input  imem_req, imem_addr, ValidD, InstrD, PCD, PCPlus4D,
        output imem_gnt, imem_rvalid, imem_rdata, StallD, PCSrcE, PCTargetE
    );

endinterface

// File: rtl/if_prefetch_unit_fetch_queue.sv
// rtl/if_prefetch_unit_fetch_queue.sv - in-order {pc, instr} FIFO; flush wins over push and pop
module fetch_queue
    import if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_wdata,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    fetch_entry_t  r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);
    assign w_do_push = i_push & ~i_flush & ((r_count < CW'(DEPTH)) | w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - sequential PC generation, single-outstanding fetch and redirect/kill handling
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    if_prefetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_outstanding;
    logic          r_kill;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_slots;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [31:0]   w_pcd;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;

    // Every in-flight request owns a queue slot, so a response can always be pushed.
    assign w_slots = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding};
    assign w_req   = ~bus.PCSrcE & (~r_outstanding | bus.imem_rvalid)
                   & (w_slots < (CW+1)'(DEPTH));
    assign w_grant = w_req & bus.imem_gnt;

    assign w_valid = (w_count != '0);
    assign w_push  = bus.imem_rvalid & ~r_kill & ~bus.PCSrcE;
    assign w_pop   = w_valid & ~bus.StallD & ~bus.PCSrcE;
    assign w_wdata = '{pc: r_req_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_kill        <= 1'b0;
        end else if (bus.PCSrcE) begin
            // A response landing this cycle is dropped here; only a later one needs killing.
            r_fetch_pc    <= bus.PCTargetE & 32'hFFFF_FFFC;
            r_kill        <= r_outstanding & ~bus.imem_rvalid;
            r_outstanding <= r_outstanding & ~bus.imem_rvalid;
        end else begin
            if (w_grant) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_req_pc      <= r_fetch_pc;
                r_outstanding <= 1'b1;
            end else if (bus.imem_rvalid) begin
                r_outstanding <= 1'b0;
            end
            if (bus.imem_rvalid) r_kill <= 1'b0;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.PCSrcE),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_pcd        = w_valid ? w_head.pc : 32'h0;
    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc & 32'hFFFF_FFFC;
    assign bus.ValidD    = w_valid;
    assign bus.InstrD    = w_valid ? w_head.instr : NOP_INSTR;
    assign bus.PCD       = w_pcd;
    assign bus.PCPlus4D  = w_pcd + 32'd4;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed scoreboard bench for if_prefetch_unit
module tb_if_prefetch_unit;
    import if_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_unit_if bus  ();
    if_prefetch_unit_if bus2 ();

    if_prefetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    if_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat   = 1;
    int          cyc;
    logic [31:0] exp_q   [$];
    logic [31:0] req_log [$];
    logic [31:0] log2    [$];
    logic [31:0] mon_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory model for the main DUT: in-order, configurable latency, data = ~addr.
    initial begin : mem1
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            bus.imem_rvalid = 1'b0;
            if (reset) pend = 1'b0;
            else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = ~paddr;
                    pend = 1'b0;
                end
            end
            @(negedge clk);
            if (!reset && bus.imem_req && bus.imem_gnt) begin
                pend = 1'b1; cnt = lat; paddr = bus.imem_addr;
                req_log.push_back(bus.imem_addr);
            end
        end
    end

    // One-cycle memory for the wrap-around instance.
    initial begin : mem2
        logic        pend;
        logic [31:0] paddr;
        pend = 1'b0; paddr = '0;
        bus2.imem_rvalid = 1'b0;
        bus2.imem_rdata  = '0;
        bus2.imem_gnt    = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus2.imem_rvalid = 1'b0;
            if (!reset && pend) begin
                bus2.imem_rvalid = 1'b1;
                bus2.imem_rdata  = ~paddr;
            end
            pend = 1'b0;
            @(negedge clk);
            if (!reset && bus2.imem_req && bus2.imem_gnt) begin
                pend = 1'b1; paddr = bus2.imem_addr;
                log2.push_back(bus2.imem_addr);
            end
        end
    end

    // Scoreboard consumer: compares every instruction the decode stage takes.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && bus.ValidD && !bus.StallD && !bus.PCSrcE) begin
                chk("sb_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_pc = exp_q.pop_front();
                    chk("PCD", bus.PCD, mon_pc);
                    chk("InstrD", bus.InstrD, ~mon_pc);
                    chk("PCPlus4D", bus.PCPlus4D, mon_pc + 32'd4);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic stall);
        @(posedge clk); #3;
        reset = 1'b1;
        bus.StallD = 1'b1; bus.PCSrcE = 1'b0; bus.PCTargetE = '0; bus.imem_gnt = 1'b1;
        bus2.StallD = 1'b1; bus2.PCSrcE = 1'b0; bus2.PCTargetE = '0;
        exp_q.delete(); req_log.delete(); log2.delete();
        repeat (2) @(posedge clk); #3;
        bus.StallD = stall;
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            @(posedge clk);
            cycles++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        logic found;
        bus.StallD = 1'b1; bus.PCSrcE = 1'b0; bus.PCTargetE = '0; bus.imem_gnt = 1'b1;
        bus2.StallD = 1'b1; bus2.PCSrcE = 1'b0; bus2.PCTargetE = '0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_ValidD", 32'(bus.ValidD), 32'd0);
        chk("rst_InstrD", bus.InstrD, NOP_INSTR);
        chk("rst_PCD", bus.PCD, 32'h0);
        chk("rst_PCPlus4D", bus.PCPlus4D, 32'h4);

        // Streaming with 1-cycle memory
        lat = 1;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_ValidD", 32'(bus.ValidD), 32'd0);
        drain(40, cyc);
        #1 bus.StallD = 1'b1;
        chk("stream_cycles", 32'(cyc), 32'd10);
        for (int i = 0; i < 8; i++) chk("stream_addr", req_log[i], 32'(4 * i));

        // Stall fills exactly DEPTH entries, then release
        do_reset(1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_req", 32'(bus.imem_req), 32'd0);
        chk("full_grants", 32'(req_log.size()), 32'd4);
        chk("full_ValidD", 32'(bus.ValidD), 32'd1);
        chk("full_PCD", bus.PCD, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        @(posedge clk); #1 bus.StallD = 1'b0;
        drain(40, cyc);
        #1 bus.StallD = 1'b1;

        // Redirect with a request in flight (3-cycle memory)
        lat = 3;
        do_reset(1'b0);
        exp_q.push_back(32'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt && bus.imem_addr == 32'h8) found = 1'b1;
        end
        chk("found_req8", 32'(found), 32'd1);
        @(posedge clk); #1;
        chk("pre_redirect_consumed", 32'(exp_q.size()), 32'd0);
        req_log.delete();
        bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h100;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        @(posedge clk); #1 bus.PCSrcE = 1'b0;
        @(negedge clk);
        chk("redir_ValidD", 32'(bus.ValidD), 32'd0);
        chk("redir_wait_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk("redir_req", 32'(bus.imem_req), 32'd1);
        chk("redir_addr", bus.imem_addr, 32'h100);
        drain(60, cyc);
        #1 bus.StallD = 1'b1;
        chk("redir_first_grant", req_log[0], 32'h100);
        lat = 1;

        // Redirect coinciding with response and pop; unaligned target
        do_reset(1'b0);
        exp_q.push_back(32'h0);
        repeat (3) @(posedge clk);
        #1 bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h203;
        @(negedge clk);
        chk("same_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk); #1 bus.PCSrcE = 1'b0;
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        @(negedge clk);
        chk("same_ValidD", 32'(bus.ValidD), 32'd0);
        chk("same_req_after", 32'(bus.imem_req), 32'd1);
        chk("same_addr", bus.imem_addr, 32'h200);
        drain(30, cyc);
        #1 bus.StallD = 1'b1;

        // PC wrap-around on the second instance
        do_reset(1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("wrap_grants", 32'(log2.size()), 32'd4);
        chk("wrap_addr0", log2[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", log2[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", log2[2], 32'h0000_0000);
        chk("wrap_PCD0", bus2.PCD, 32'hFFFF_FFF8);
        @(posedge clk); #1 bus2.StallD = 1'b0;
        @(posedge clk); #1 bus2.StallD = 1'b1;
        @(negedge clk);
        chk("wrap_PCD1", bus2.PCD, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4D", bus2.PCPlus4D, 32'h0);
        chk("wrap_InstrD", bus2.InstrD, 32'h0000_0003);

        // Asynchronous reset with two queued entries
        do_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            if (req_log.size() >= 2) found = 1'b1;
        end
        #1 bus.imem_gnt = 1'b0;
        chk("mid_two_grants", 32'(found), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_ValidD", 32'(bus.ValidD), 32'd1);
        chk("mid_PCD", bus.PCD, 32'h0);
        chk("mid_grants", 32'(req_log.size()), 32'd2);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("async_ValidD", 32'(bus.ValidD), 32'd0);
        chk("async_InstrD", bus.InstrD, NOP_INSTR);
        chk("async_PCD", bus.PCD, 32'h0);
        @(posedge clk); #3;
        reset = 1'b0; bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", bus.imem_addr, 32'h0);
        chk("restart_addr_wrap", bus2.imem_addr, 32'hFFFF_FFF8);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
